// File: rtl/cache_stat_monitor.sv
// -----------------------------------------------------------------------------
// cache_stat_monitor
//
// Passive direct-mapped cache model that watches one memory request stream
// and keeps hit/miss statistics. It does not stall or alter the traffic.
// A tag/valid shadow array holds the cache state. Lookup is combinational
// in the request cycle, and the result appears on the registered outputs one
// cycle later.
//
// Parameters:
//   ADDR_W         request address width
//   NUM_SETS       number of direct-mapped lines (power of two, >= 2)
//   BLOCK_BYTES    line size in bytes (power of two, >= 4)
//   WRITE_ALLOCATE 1 = a write miss allocates the line, 0 = it does not
//   CNT_W          width of each saturating statistics counter
//
// Ports:
//   clk           clock
//   rst_n         asynchronous active-low reset
//   clear         synchronous clear: zeroes the counters, invalidates all
//                 lines and drops a request in the same cycle
//   req_valid     one access this cycle
//   req_addr      byte address of the access
//   req_we        1 = write, 0 = read
//   lookup_valid  a lookup completed on the last edge
//   lookup_hit    hit/miss result of that lookup (holds while idle)
//   access_count  accepted accesses
//   hit_count     accepted accesses that hit
//   miss_count    accepted accesses that missed
//   write_count   accepted accesses with req_we = 1
// -----------------------------------------------------------------------------
module cache_stat_monitor #(
    parameter int ADDR_W         = 32,
    parameter int NUM_SETS       = 64,
    parameter int BLOCK_BYTES    = 16,
    parameter int WRITE_ALLOCATE = 1,
    parameter int CNT_W          = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_we,
    output logic              lookup_valid,
    output logic              lookup_hit,
    output logic [CNT_W-1:0]  access_count,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count,
    output logic [CNT_W-1:0]  write_count
);

    localparam int OFFSET_W = $clog2(BLOCK_BYTES);
    localparam int INDEX_W  = $clog2(NUM_SETS);
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam bit WA_EN    = (WRITE_ALLOCATE != 32'sd0);

    // Increment that stops at all-ones instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (&value) begin
            result = value;
        end else begin
            result = value + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

    // Shadow array state
    logic [NUM_SETS-1:0] valid_r;
    logic [TAG_W-1:0]    tag_mem_r [NUM_SETS];

    // Statistics and result registers
    logic [CNT_W-1:0]    access_cnt_r;
    logic [CNT_W-1:0]    hit_cnt_r;
    logic [CNT_W-1:0]    miss_cnt_r;
    logic [CNT_W-1:0]    write_cnt_r;
    logic                lookup_valid_r;
    logic                lookup_hit_r;

    // Request-cycle decode
    logic [INDEX_W-1:0]  index_s;
    logic [TAG_W-1:0]    tag_s;
    logic                hit_s;
    logic                accept_s;
    logic                alloc_s;

    // The byte offset within a line does not affect the lookup.
    logic                unused_offset_s;
    assign unused_offset_s = ^req_addr[OFFSET_W-1:0];

    // Address split, combinational lookup and the allocation decision.
    // The request is dropped entirely when it coincides with clear.
    always_comb begin
        index_s  = req_addr[OFFSET_W +: INDEX_W];
        tag_s    = req_addr[ADDR_W-1 -: TAG_W];
        hit_s    = valid_r[index_s] && (tag_mem_r[index_s] == tag_s);
        accept_s = req_valid && !clear;
        if (accept_s && !hit_s && (!req_we || WA_EN)) begin
            alloc_s = 1'b1;
        end else begin
            alloc_s = 1'b0;
        end
    end

    // Valid bits: cleared by reset and by clear, set when a line is allocated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
        end else if (clear) begin
            valid_r <= '0;
        end else if (alloc_s) begin
            valid_r[index_s] <= 1'b1;
        end
    end

    // Tag storage. It is only read behind a valid bit, so it needs no reset.
    always_ff @(posedge clk) begin
        if (alloc_s) begin
            tag_mem_r[index_s] <= tag_s;
        end
    end

    // Saturating statistics counters. Each one saturates independently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            access_cnt_r <= '0;
            hit_cnt_r    <= '0;
            miss_cnt_r   <= '0;
            write_cnt_r  <= '0;
        end else if (clear) begin
            access_cnt_r <= '0;
            hit_cnt_r    <= '0;
            miss_cnt_r   <= '0;
            write_cnt_r  <= '0;
        end else if (accept_s) begin
            access_cnt_r <= sat_inc(access_cnt_r);
            if (hit_s) begin
                hit_cnt_r <= sat_inc(hit_cnt_r);
            end else begin
                miss_cnt_r <= sat_inc(miss_cnt_r);
            end
            if (req_we) begin
                write_cnt_r <= sat_inc(write_cnt_r);
            end
        end
    end

    // One-cycle-late lookup result. The hit flag keeps its value between
    // requests, so software can still read the result of the last access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lookup_valid_r <= 1'b0;
            lookup_hit_r   <= 1'b0;
        end else if (accept_s) begin
            lookup_valid_r <= 1'b1;
            lookup_hit_r   <= hit_s;
        end else begin
            lookup_valid_r <= 1'b0;
        end
    end

    assign lookup_valid = lookup_valid_r;
    assign lookup_hit   = lookup_hit_r;
    assign access_count = access_cnt_r;
    assign hit_count    = hit_cnt_r;
    assign miss_count   = miss_cnt_r;
    assign write_count  = write_cnt_r;

endmodule

// File: tb/tb_cache_stat_monitor.sv
// -----------------------------------------------------------------------------
// Bench for cache_stat_monitor. Three instances share one stimulus stream:
//   dut0: NUM_SETS=4, BLOCK_BYTES=16, WRITE_ALLOCATE=1, CNT_W=32
//   dut1: same geometry, WRITE_ALLOCATE=0
//   dut2: same geometry, WRITE_ALLOCATE=1, CNT_W=4 (saturation)
// With this geometry the index is addr[5:4] and the tag is addr[31:6].
// -----------------------------------------------------------------------------
module tb_cache_stat_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_we;

    logic        lv0, lh0, lv1, lh1, lv2, lh2;
    logic [31:0] acc0, hit0, miss0, wr0;
    logic [31:0] acc1, hit1, miss1, wr1;
    logic [3:0]  acc2, hit2, miss2, wr2;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cache_stat_monitor #(.ADDR_W(32), .NUM_SETS(4), .BLOCK_BYTES(16), .WRITE_ALLOCATE(1), .CNT_W(32)) dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .req_valid(req_valid), .req_addr(req_addr),
        .req_we(req_we), .lookup_valid(lv0), .lookup_hit(lh0), .access_count(acc0),
        .hit_count(hit0), .miss_count(miss0), .write_count(wr0));

    cache_stat_monitor #(.ADDR_W(32), .NUM_SETS(4), .BLOCK_BYTES(16), .WRITE_ALLOCATE(0), .CNT_W(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .req_valid(req_valid), .req_addr(req_addr),
        .req_we(req_we), .lookup_valid(lv1), .lookup_hit(lh1), .access_count(acc1),
        .hit_count(hit1), .miss_count(miss1), .write_count(wr1));

    cache_stat_monitor #(.ADDR_W(32), .NUM_SETS(4), .BLOCK_BYTES(16), .WRITE_ALLOCATE(1), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .req_valid(req_valid), .req_addr(req_addr),
        .req_we(req_we), .lookup_valid(lv2), .lookup_hit(lh2), .access_count(acc2),
        .hit_count(hit2), .miss_count(miss2), .write_count(wr2));

    // ---------------- reference model (one per instance) ----------------
    bit          m_valid [3][4];
    int unsigned m_tag   [3][4];
    longint      m_acc[3], m_hit[3], m_miss[3], m_wr[3], m_max[3];
    bit          m_lv[3], m_lh[3], m_wa[3];

    task automatic m_reset();
        for (int i = 0; i < 3; i++) begin
            for (int s = 0; s < 4; s++) m_valid[i][s] = 1'b0;
            m_acc[i] = 0; m_hit[i] = 0; m_miss[i] = 0; m_wr[i] = 0;
            m_lv[i] = 1'b0; m_lh[i] = 1'b0;
        end
    endtask

    task automatic m_edge(input bit v, input logic [31:0] addr, input bit we, input bit clr);
        int unsigned idx, tg;
        bit h;
        idx = (addr / 16) % 4;
        tg  = addr / 64;
        for (int i = 0; i < 3; i++) begin
            if (clr) begin
                for (int s = 0; s < 4; s++) m_valid[i][s] = 1'b0;
                m_acc[i] = 0; m_hit[i] = 0; m_miss[i] = 0; m_wr[i] = 0;
                m_lv[i] = 1'b0;
            end else if (v) begin
                h = m_valid[i][idx] && (m_tag[i][idx] == tg);
                if (m_acc[i] < m_max[i]) m_acc[i]++;
                if (h && m_hit[i] < m_max[i]) m_hit[i]++;
                if (!h && m_miss[i] < m_max[i]) m_miss[i]++;
                if (we && m_wr[i] < m_max[i]) m_wr[i]++;
                if (!h && (!we || m_wa[i])) begin
                    m_valid[i][idx] = 1'b1;
                    m_tag[i][idx]   = tg;
                end
                m_lv[i] = 1'b1;
                m_lh[i] = h;
            end else begin
                m_lv[i] = 1'b0;
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(input int i, input bit a_lv, input bit a_lh, input longint a_acc,
                           input longint a_hit, input longint a_miss, input longint a_wr);
        chk($sformatf("dut%0d lookup_valid", i), a_lv, m_lv[i]);
        if (m_lv[i]) chk($sformatf("dut%0d lookup_hit", i), a_lh, m_lh[i]);
        chk($sformatf("dut%0d access_count", i), a_acc, m_acc[i]);
        chk($sformatf("dut%0d hit_count", i), a_hit, m_hit[i]);
        chk($sformatf("dut%0d miss_count", i), a_miss, m_miss[i]);
        chk($sformatf("dut%0d write_count", i), a_wr, m_wr[i]);
    endtask

    task automatic compare_all();
        cmp_dut(0, lv0, lh0, acc0, hit0, miss0, wr0);
        cmp_dut(1, lv1, lh1, acc1, hit1, miss1, wr1);
        cmp_dut(2, lv2, lh2, {28'd0, acc2}, {28'd0, hit2}, {28'd0, miss2}, {28'd0, wr2});
    endtask

    // Drive one cycle away from the edge, advance the model on the edge and
    // leave the caller 1 ns after the edge, ready to sample.
    task automatic do_cycle(input bit v, input logic [31:0] addr, input bit we, input bit clr);
        req_valid = v; req_addr = addr; req_we = we; clear = clr;
        @(posedge clk);
        m_edge(v, addr, we, clr);
        #1;
    endtask

    // ---------------- directed table (expectations for dut0) ----------------
    typedef struct {
        bit          v;
        logic [31:0] addr;
        bit          we;
        bit          clr;
        bit          e_lv;
        bit          e_lh;
        int          e_acc;
        int          e_hit;
        int          e_miss;
        int          e_wr;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{1'b1, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 1, 0}; // cold miss
        tbl[1]  = '{1'b1, 32'h04, 1'b0, 1'b0, 1'b1, 1'b1, 2, 1, 1, 0}; // same block
        tbl[2]  = '{1'b1, 32'h0C, 1'b0, 1'b0, 1'b1, 1'b1, 3, 2, 1, 0}; // same block
        tbl[3]  = '{1'b1, 32'h00, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0}; // clear drops req
        tbl[4]  = '{1'b1, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 1, 0}; // miss after clear
        tbl[5]  = '{1'b1, 32'h40, 1'b0, 1'b0, 1'b1, 1'b0, 2, 0, 2, 0}; // conflict
        tbl[6]  = '{1'b1, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3, 0, 3, 0}; // conflict back
        tbl[7]  = '{1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 1'b0, 4, 0, 4, 0}; // index 1
        tbl[8]  = '{1'b1, 32'h00, 1'b0, 1'b0, 1'b1, 1'b1, 5, 1, 4, 0}; // index 0 kept
        tbl[9]  = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5, 1, 4, 0}; // idle
        tbl[10] = '{1'b1, 32'h80, 1'b1, 1'b0, 1'b1, 1'b0, 6, 1, 5, 1}; // write miss, alloc
        tbl[11] = '{1'b1, 32'h80, 1'b0, 1'b0, 1'b1, 1'b1, 7, 2, 5, 1}; // read hit
    end

    // ---------------- main sequence ----------------
    initial begin
        m_wa[0] = 1'b1; m_wa[1] = 1'b0; m_wa[2] = 1'b1;
        m_max[0] = 64'd4294967295; m_max[1] = 64'd4294967295; m_max[2] = 64'd15;
        m_reset();
        rst_n = 1'b0; clear = 1'b0; req_valid = 1'b0; req_addr = 32'h0; req_we = 1'b0;
        #7;
        compare_all();                       // reset state
        #5 rst_n = 1'b1;

        // Table vectors: reads, conflicts, clear with request, write allocate.
        for (int k = 0; k < 12; k++) begin
            do_cycle(tbl[k].v, tbl[k].addr, tbl[k].we, tbl[k].clr);
            chk($sformatf("tbl[%0d] lookup_valid", k), lv0, tbl[k].e_lv);
            if (tbl[k].e_lv) chk($sformatf("tbl[%0d] lookup_hit", k), lh0, tbl[k].e_lh);
            chk($sformatf("tbl[%0d] access", k), acc0, tbl[k].e_acc);
            chk($sformatf("tbl[%0d] hit", k), hit0, tbl[k].e_hit);
            chk($sformatf("tbl[%0d] miss", k), miss0, tbl[k].e_miss);
            chk($sformatf("tbl[%0d] write", k), wr0, tbl[k].e_wr);
            compare_all();
        end

        // Write miss with and without allocation.
        do_cycle(1'b0, 32'h0, 1'b0, 1'b1);
        do_cycle(1'b1, 32'h80, 1'b1, 1'b0);
        chk("wa0 write lookup_hit", lh1, 0);
        chk("wa1 write lookup_hit", lh0, 0);
        do_cycle(1'b1, 32'h80, 1'b0, 1'b0);
        chk("wa0 read lookup_hit", lh1, 0);
        chk("wa0 miss_count", miss1, 2);
        chk("wa0 write_count", wr1, 1);
        chk("wa1 read lookup_hit", lh0, 1);
        compare_all();

        // Saturation of the 4-bit counters.
        do_cycle(1'b0, 32'h0, 1'b0, 1'b1);
        for (int n = 0; n < 20; n++) begin
            do_cycle(1'b1, 32'h00, 1'b0, 1'b0);
            compare_all();
        end
        chk("sat access", acc2, 15);
        chk("sat hit", hit2, 15);
        chk("sat miss", miss2, 1);
        chk("nosat access", acc0, 20);

        // Asynchronous reset between edges, mid-stream.
        do_cycle(1'b1, 32'h10, 1'b0, 1'b0);
        do_cycle(1'b1, 32'h10, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async lookup_valid", lv0, 0);
        chk("async lookup_hit", lh0, 0);
        chk("async access", acc0, 0);
        chk("async hit", hit0, 0);
        chk("async miss", miss2, 0);
        m_reset();
        @(negedge clk) rst_n = 1'b1;
        do_cycle(1'b1, 32'h10, 1'b0, 1'b0);
        chk("post-reset lookup_hit", lh0, 0);
        chk("post-reset miss", miss0, 1);
        compare_all();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) << 28) | $urandom_range(0, 255);
            do_cycle($urandom_range(0, 3) != 0, a, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 99) == 0);
            compare_all();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
